tbird_seq_ctrl: RTL and testbench

- Sequencing controller for the Thunderbird tail-light outputs (la, lb, lc, ra, rb, rc).
- Adds a programmable step rate, a hazard mode and a brake overlay on top of the basic left/right turn sequence.
- Sits between the driver-input synchronisers and the lamp drivers.
- Replaces the free-running one-step-per-clock tail-light FSM in designs that need a slower blink rate.

---
 rtl/tbird_seq_ctrl_if.sv | 39 +++
 rtl/tbird_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_tbird_seq_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/tbird_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// tbird_seq_ctrl_if
// Bundles the driver requests and the lamp outputs of the Thunderbird
// tail-light sequencer. The clock and reset are not part of this bundle.
//
//   left, right  turn requests, synchronous to clk
//   hazard       hazard request, synchronous to clk
//   brake        brake pedal, synchronous to clk
//   la, lb, lc   left lamps, la innermost
//   ra, rb, rc   right lamps, ra innermost
//   busy         high whenever the sequencer is not idle
//
// Modports:
//   master  the request source (drives requests, observes lamps)
//   slave   the sequencer (observes requests, drives lamps)
// -----------------------------------------------------------------------------
interface tbird_seq_ctrl_if;
  logic left;
  logic right;
  logic hazard;
  logic brake;
  logic la;
  logic lb;
  logic lc;
  logic ra;
  logic rb;
  logic rc;
  logic busy;

  modport master (
    output left, right, hazard, brake,
    input  la, lb, lc, ra, rb, rc, busy
  );

  modport slave (
    input  left, right, hazard, brake,
    output la, lb, lc, ra, rb, rc, busy
  );
endinterface

// File: rtl/tbird_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tbird_seq_ctrl
// Thunderbird tail-light sequencer with a programmable step rate, a hazard
// mode and a brake overlay. Each non-idle state lasts TICK_DIV clock cycles,
// except that a hazard request aborts a turn sequence on the next edge.
//
// Parameters:
//   TICK_DIV  clock cycles per light step (1..65535)
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    request/lamp bundle (slave side):
//            left, right, hazard, brake in; la..lc, ra..rc, busy out
//
// The lamps are decoded from the registered state only, with brake overlaid
// combinationally, so brake reaches the lamps without a clock delay and
// never affects state or step timing.
// -----------------------------------------------------------------------------
module tbird_seq_ctrl #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  tbird_seq_ctrl_if.slave  bus
);

  localparam int unsigned      CNT_W    = $clog2(TICK_DIV + 1);
  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    L1    = 4'd1,
    L2    = 4'd2,
    L3    = 4'd3,
    R1    = 4'd4,
    R2    = 4'd5,
    R3    = 4'd6,
    HAZ   = 4'd7,
    PAUSE = 4'd8
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             tick_s;

  logic [2:0]       left_base_s;   // {la, lb, lc} before brake overlay
  logic [2:0]       right_base_s;  // {ra, rb, rc} before brake overlay
  logic             left_active_s;
  logic             right_active_s;
  logic [2:0]       left_lamps_s;
  logic [2:0]       right_lamps_s;

  // With TICK_DIV=1 the counter never leaves 0, so tick is constantly high.
  assign tick_s = (cnt_r == TICK_MAX);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Step counter: held at 0 in IDLE, cleared on every transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if ((next_state_s != state_r) || (state_r == IDLE)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Next-state logic. Hazard aborts a turn sequence regardless of tick;
  // once a turn sequence starts it ignores the turn requests themselves.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.hazard || (bus.left && bus.right)) begin
          next_state_s = HAZ;
        end else if (bus.left) begin
          next_state_s = L1;
        end else if (bus.right) begin
          next_state_s = R1;
        end else begin
          next_state_s = IDLE;
        end
      end
      L1: begin
        if (bus.hazard) begin
          next_state_s = HAZ;
        end else if (tick_s) begin
          next_state_s = L2;
        end else begin
          next_state_s = L1;
        end
      end
      L2: begin
        if (bus.hazard) begin
          next_state_s = HAZ;
        end else if (tick_s) begin
          next_state_s = L3;
        end else begin
          next_state_s = L2;
        end
      end
      L3: begin
        if (bus.hazard) begin
          next_state_s = HAZ;
        end else if (tick_s) begin
          next_state_s = PAUSE;
        end else begin
          next_state_s = L3;
        end
      end
      R1: begin
        if (bus.hazard) begin
          next_state_s = HAZ;
        end else if (tick_s) begin
          next_state_s = R2;
        end else begin
          next_state_s = R1;
        end
      end
      R2: begin
        if (bus.hazard) begin
          next_state_s = HAZ;
        end else if (tick_s) begin
          next_state_s = R3;
        end else begin
          next_state_s = R2;
        end
      end
      R3: begin
        if (bus.hazard) begin
          next_state_s = HAZ;
        end else if (tick_s) begin
          next_state_s = PAUSE;
        end else begin
          next_state_s = R3;
        end
      end
      HAZ: begin
        if (tick_s) begin
          next_state_s = PAUSE;
        end else begin
          next_state_s = HAZ;
        end
      end
      // A hazard request seen here is picked up from IDLE, not here.
      PAUSE: begin
        if (tick_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = PAUSE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Moore lamp decode from the registered state.
  always_comb begin
    left_base_s    = 3'b000;
    right_base_s   = 3'b000;
    left_active_s  = 1'b0;
    right_active_s = 1'b0;
    case (state_r)
      IDLE: begin
        left_base_s  = 3'b000;
        right_base_s = 3'b000;
      end
      L1: begin
        left_base_s   = 3'b100;
        left_active_s = 1'b1;
      end
      L2: begin
        left_base_s   = 3'b110;
        left_active_s = 1'b1;
      end
      L3: begin
        left_base_s   = 3'b111;
        left_active_s = 1'b1;
      end
      R1: begin
        right_base_s   = 3'b100;
        right_active_s = 1'b1;
      end
      R2: begin
        right_base_s   = 3'b110;
        right_active_s = 1'b1;
      end
      R3: begin
        right_base_s   = 3'b111;
        right_active_s = 1'b1;
      end
      HAZ: begin
        left_base_s    = 3'b111;
        right_base_s   = 3'b111;
        left_active_s  = 1'b1;
        right_active_s = 1'b1;
      end
      PAUSE: begin
        left_base_s  = 3'b000;
        right_base_s = 3'b000;
      end
      default: begin
        left_base_s  = 3'b000;
        right_base_s = 3'b000;
      end
    endcase
  end

  // Brake overlay: a side that is not sequencing lights fully while braking.
  always_comb begin
    left_lamps_s  = left_base_s;
    right_lamps_s = right_base_s;
    if (bus.brake && !left_active_s) begin
      left_lamps_s = 3'b111;
    end else begin
      left_lamps_s = left_base_s;
    end
    if (bus.brake && !right_active_s) begin
      right_lamps_s = 3'b111;
    end else begin
      right_lamps_s = right_base_s;
    end
  end

  assign bus.la   = left_lamps_s[2];
  assign bus.lb   = left_lamps_s[1];
  assign bus.lc   = left_lamps_s[0];
  assign bus.ra   = right_lamps_s[2];
  assign bus.rb   = right_lamps_s[1];
  assign bus.rc   = right_lamps_s[0];
  assign bus.busy = (state_r != IDLE);

endmodule

// File: tb/tb_tbird_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tbird_seq_ctrl
// Directed bench for tbird_seq_ctrl. Two instances share clock, reset and
// requests: one with TICK_DIV=4 and one with TICK_DIV=1. Expected lamp
// vectors {la,lb,lc,ra,rb,rc,busy} are queued as each step is driven and
// popped when the selected instance is sampled.
// -----------------------------------------------------------------------------
module tb_tbird_seq_ctrl;

  localparam logic [6:0] V_OFF   = 7'b000000_0;
  localparam logic [6:0] V_L1    = 7'b100000_1;
  localparam logic [6:0] V_L2    = 7'b110000_1;
  localparam logic [6:0] V_L3    = 7'b111000_1;
  localparam logic [6:0] V_R1    = 7'b000100_1;
  localparam logic [6:0] V_R2    = 7'b000110_1;
  localparam logic [6:0] V_R3    = 7'b000111_1;
  localparam logic [6:0] V_HAZ   = 7'b111111_1;
  localparam logic [6:0] V_PAUSE = 7'b000000_1;
  localparam logic [6:0] V_BRK_L2    = 7'b110111_1;
  localparam logic [6:0] V_BRK_PAUSE = 7'b111111_1;
  localparam logic [6:0] V_BRK_IDLE  = 7'b111111_0;

  logic clk = 1'b0;
  logic reset;
  logic left;
  logic right;
  logic hazard;
  logic brake;
  logic sel;  // 0: TICK_DIV=4 instance, 1: TICK_DIV=1 instance

  int checks = 0;
  int errors = 0;
  logic [6:0] sb_q[$];

  tbird_seq_ctrl_if if4 ();
  tbird_seq_ctrl_if if1 ();

  assign if4.left   = left;
  assign if4.right  = right;
  assign if4.hazard = hazard;
  assign if4.brake  = brake;
  assign if1.left   = left;
  assign if1.right  = right;
  assign if1.hazard = hazard;
  assign if1.brake  = brake;

  tbird_seq_ctrl #(.TICK_DIV(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  tbird_seq_ctrl #(.TICK_DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  logic [6:0] obs4;
  logic [6:0] obs1;
  assign obs4 = {if4.la, if4.lb, if4.lc, if4.ra, if4.rb, if4.rc, if4.busy};
  assign obs1 = {if1.la, if1.lb, if1.lc, if1.ra, if1.rb, if1.rc, if1.busy};

  always #5 clk = ~clk;

  task automatic compare(input string tag);
    logic [6:0] got;
    logic [6:0] exp;
    got = sel ? obs1 : obs4;
    exp = sb_q.pop_front();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // One clock step, sampled 1 time unit after the rising edge.
  task automatic cyc(input logic [6:0] e, input string tag);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic run(input logic [6:0] e, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc(e, tag);
    end
  endtask

  // Sample without a clock edge (combinational paths).
  task automatic now_chk(input logic [6:0] e, input string tag);
    sb_q.push_back(e);
    #1;
    compare(tag);
  endtask

  initial begin
    reset  = 1'b0;
    left   = 1'b0;
    right  = 1'b0;
    hazard = 1'b0;
    brake  = 1'b0;
    sel    = 1'b0;

    // Reset state, both instances.
    #2;
    now_chk(V_OFF, "reset4");
    sel = 1'b1;
    now_chk(V_OFF, "reset1");
    sel = 1'b0;
    #8;
    reset = 1'b1;
    run(V_OFF, 2, "idle");

    // Single-cycle left pulse: full left sequence at TICK_DIV=4.
    left = 1'b1;
    cyc(V_L1, "left_l1");
    left = 1'b0;
    run(V_L1, 3, "left_l1");
    run(V_L2, 4, "left_l2");
    run(V_L3, 4, "left_l3");
    run(V_PAUSE, 4, "left_pause");
    run(V_OFF, 3, "left_idle");

    // Held right: 17-cycle period, left lamps dark throughout.
    right = 1'b1;
    run(V_R1, 4, "right_r1");
    run(V_R2, 4, "right_r2");
    run(V_R3, 4, "right_r3");
    run(V_PAUSE, 4, "right_pause");
    cyc(V_OFF, "right_idle_gap");
    run(V_R1, 4, "right_r1_again");
    right = 1'b0;
    run(V_R2, 4, "right_r2_again");
    run(V_R3, 4, "right_r3_again");
    run(V_PAUSE, 4, "right_pause_again");
    run(V_OFF, 2, "right_idle");

    // Hazard at the second cycle of L2 aborts the left sequence.
    left = 1'b1;
    cyc(V_L1, "abort_l1");
    left = 1'b0;
    run(V_L1, 3, "abort_l1");
    run(V_L2, 2, "abort_l2");
    hazard = 1'b1;
    cyc(V_HAZ, "abort_haz");
    hazard = 1'b0;
    run(V_HAZ, 3, "abort_haz");
    run(V_PAUSE, 4, "abort_pause");
    run(V_OFF, 2, "abort_idle");

    // left and right together from IDLE select hazard.
    left  = 1'b1;
    right = 1'b1;
    cyc(V_HAZ, "both_haz");
    left  = 1'b0;
    right = 1'b0;
    run(V_HAZ, 3, "both_haz");
    run(V_PAUSE, 4, "both_pause");
    cyc(V_OFF, "both_idle");

    // Brake overlay during L2, PAUSE and IDLE; timing must not shift.
    left = 1'b1;
    cyc(V_L1, "brk_l1");
    left = 1'b0;
    run(V_L1, 3, "brk_l1");
    cyc(V_L2, "brk_l2_first");
    brake = 1'b1;
    now_chk(V_BRK_L2, "brk_l2_comb");
    cyc(V_BRK_L2, "brk_l2_second");
    brake = 1'b0;
    now_chk(V_L2, "brk_l2_release");
    cyc(V_L2, "brk_l2_third");
    brake = 1'b1;
    cyc(V_BRK_L2, "brk_l2_fourth");
    brake = 1'b0;
    run(V_L3, 4, "brk_l3");
    brake = 1'b1;
    cyc(V_BRK_PAUSE, "brk_pause");
    brake = 1'b0;
    run(V_PAUSE, 3, "brk_pause");
    cyc(V_OFF, "brk_idle");
    brake = 1'b1;
    now_chk(V_BRK_IDLE, "brk_idle_comb");
    brake = 1'b0;
    now_chk(V_OFF, "brk_idle_release");

    // Asynchronous reset in the middle of R3.
    right = 1'b1;
    cyc(V_R1, "rst_r1");
    right = 1'b0;
    run(V_R1, 3, "rst_r1");
    run(V_R2, 4, "rst_r2");
    run(V_R3, 2, "rst_r3");
    #2;
    reset = 1'b0;
    now_chk(V_OFF, "rst_async");
    #3;
    reset = 1'b1;

    // TICK_DIV=1 with left held: one cycle per step.
    sel  = 1'b1;
    left = 1'b1;
    cyc(V_L1, "div1_l1");
    cyc(V_L2, "div1_l2");
    cyc(V_L3, "div1_l3");
    cyc(V_PAUSE, "div1_pause");
    cyc(V_OFF, "div1_idle");
    cyc(V_L1, "div1_l1_again");
    left = 1'b0;
    cyc(V_L2, "div1_l2_again");
    cyc(V_L3, "div1_l3_again");
    cyc(V_PAUSE, "div1_pause_again");
    run(V_OFF, 2, "div1_idle_again");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
